// File: rtl/csa_accum_sched.sv
// Multi-operand accumulator: 3:2 carry-save compression per operand, then a chunked ripple resolve.
// Optional cycle counter port run_cycles when CSA_ACCUM_PERF_EN is defined.
module csa_accum_sched #(
   parameter int unsigned N     = 32,
   parameter int unsigned CNT_W = 4,
   parameter int unsigned CHUNK = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [CNT_W-1:0]   num_ops,
   output logic               busy,
   input  logic               op_valid,
   input  logic [N-1:0]       op_data,
   output logic               op_ready,
   output logic               res_valid,
   output logic [N+CNT_W-1:0] res_data,
`ifdef CSA_ACCUM_PERF_EN
   output logic [15:0]        run_cycles,
`endif
   input  logic               res_ready
);

   localparam int unsigned ACC_W = N + CNT_W;
   localparam int unsigned R     = ACC_W / CHUNK;
   localparam int unsigned IDX_W = (R > 1) ? $clog2(R) : 1;

   if ((ACC_W % CHUNK) != 0) begin : g_bad_chunk
      $error("csa_accum_sched: N+CNT_W must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {st_idle, st_accum, st_resolve, st_done} state_t;

   state_t             state;
   logic [ACC_W-1:0]   s_q, c_q, res_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;

   logic [ACC_W-1:0]   x, maj;
   logic [CHUNK-1:0]   s_chunk, c_chunk;
   logic [CHUNK:0]     chunk_sum;

   assign x         = {{CNT_W{1'b0}}, op_data};
   assign maj       = (s_q & c_q) | (s_q & x) | (c_q & x);
   assign s_chunk   = s_q[int'(idx_q)*CHUNK +: CHUNK];
   assign c_chunk   = c_q[int'(idx_q)*CHUNK +: CHUNK];
   assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, carry_q};

   assign busy      = (state != st_idle);
   assign op_ready  = (state == st_accum);
   assign res_valid = (state == st_done);
   assign res_data  = res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= st_idle;
         s_q     <= '0;
         c_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         unique case (state)
            st_idle: begin
               if (start) begin
                  if (num_ops != '0) begin
                     state <= st_accum;
                     s_q   <= '0;
                     c_q   <= '0;
                     cnt_q <= num_ops;
                  end else begin
                     state <= st_done;
                     res_q <= '0;
                  end
               end
            end
            st_accum: begin
               if (op_valid) begin
                  s_q   <= s_q ^ c_q ^ x;
                  c_q   <= maj << 1;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) begin
                     state   <= st_resolve;
                     idx_q   <= '0;
                     carry_q <= 1'b0;
                  end
               end
            end
            st_resolve: begin
               res_q[int'(idx_q)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
               carry_q <= chunk_sum[CHUNK];
               idx_q   <= idx_q + 1'b1;
               // final carry-out cannot be set: ACC_W has headroom for 2^CNT_W-1 operands
               if (idx_q == IDX_W'(R - 1)) state <= st_done;
            end
            st_done: begin
               if (res_ready) state <= st_idle;
            end
            default: state <= st_idle;
         endcase
      end
   end

`ifdef CSA_ACCUM_PERF_EN
   // Loaded with 1 on start so the count includes the cycle being entered; frozen in DONE/IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cycles <= '0;
      end else if (state == st_idle) begin
         if (start) run_cycles <= 16'd1;
      end else if (state != st_done && run_cycles != 16'hFFFF) begin
         run_cycles <= run_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_csa_accum_sched.sv
// Directed self-checking bench for csa_accum_sched (default parameters, R = 9 resolve cycles).
module tb_csa_accum_sched;

   localparam int unsigned N     = 32;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned ACC_W = N + CNT_W;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] num_ops;
   logic             busy;
   logic             op_valid;
   logic [N-1:0]     op_data;
   logic             op_ready;
   logic             res_valid;
   logic [ACC_W-1:0] res_data;
   logic             res_ready;
`ifdef CSA_ACCUM_PERF_EN
   logic [15:0]      run_cycles;
`endif

   int total = 0;
   int bad   = 0;

   csa_accum_sched #(.N(N), .CNT_W(CNT_W), .CHUNK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_ops   (num_ops),
      .busy      (busy),
      .op_valid  (op_valid),
      .op_data   (op_data),
      .op_ready  (op_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
`ifdef CSA_ACCUM_PERF_EN
      .run_cycles(run_cycles),
`endif
      .res_ready (res_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [N-1:0] d);
      int n;
      op_valid = 1'b1;
      op_data  = d;
      n = 0;
      while (op_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk("op_ready_wait", {63'd0, op_ready}, 64'd1);
      step();
      op_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (res_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic kick(input logic [CNT_W-1:0] k);
      num_ops = k;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; num_ops = '0;
      op_valid = 1'b0; op_data = '0; res_ready = 1'b0;
      #2;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_op_ready", {63'd0, op_ready}, 64'd0);
      chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_res_data", {28'd0, res_data}, 64'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      // 1+2+3 back-to-back; DONE reached R cycles after the cycle following the last handshake
      res_ready = 1'b1;
      kick(3);
      chk("t1_busy", {63'd0, busy}, 64'd1);
      chk("t1_op_ready", {63'd0, op_ready}, 64'd1);
      send(1); send(2); send(3);
      chk("t1_resolve_no_ready", {63'd0, op_ready}, 64'd0);
      wait_done(n);
      chk("t1_latency", 64'(n), 64'd9);
      chk("t1_sum", {28'd0, res_data}, 64'd6);
`ifdef CSA_ACCUM_PERF_EN
      chk("t1_perf_done", {48'd0, run_cycles}, 64'd13);
`endif
      step();
      chk("t1_valid_drop", {63'd0, res_valid}, 64'd0);
      chk("t1_idle", {63'd0, busy}, 64'd0);
      chk("t1_hold", {28'd0, res_data}, 64'd6);
`ifdef CSA_ACCUM_PERF_EN
      chk("t1_perf_idle", {48'd0, run_cycles}, 64'd13);
`endif

      // 15 x 0xFFFFFFFF: full-width result, no truncation
      kick(15);
      for (int i = 0; i < 15; i++) send(32'hFFFF_FFFF);
      wait_done(n);
      chk("t2_latency", 64'(n), 64'd9);
      chk("t2_sum", {28'd0, res_data}, 64'hE_FFFF_FFF1);
      step();

      // zero-operand run goes straight to DONE with res_data cleared
      kick(0);
      chk("t3_valid", {63'd0, res_valid}, 64'd1);
      chk("t3_data", {28'd0, res_data}, 64'd0);
      chk("t3_op_ready", {63'd0, op_ready}, 64'd0);
      step();
      chk("t3_idle", {63'd0, busy}, 64'd0);

      // gapped operands, stalled consumer, stray starts
      res_ready = 1'b0;
      kick(4);
      send(32'h10);
      num_ops = 0; start = 1'b1; step(); start = 1'b0; step();
      chk("t4_stray_ignored", {63'd0, op_ready}, 64'd1);
      send(32'h20); step(); step();
      send(32'h30); step(); step();
      send(32'h40);
      wait_done(n);
      chk("t4_sum", {28'd0, res_data}, 64'hA0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_stall_valid", {63'd0, res_valid}, 64'd1);
         chk("t4_stall_data", {28'd0, res_data}, 64'hA0);
      end
      res_ready = 1'b1; num_ops = 1; start = 1'b1;
      step();
      start = 1'b0;
      chk("t4_exit_idle", {63'd0, busy}, 64'd0);
      chk("t4_exit_valid", {63'd0, res_valid}, 64'd0);
      step();
      chk("t4_single_result", {63'd0, res_valid}, 64'd0);
      chk("t4_start_ignored", {63'd0, busy}, 64'd0);

      // async reset in RESOLVE chunk 4 clears outputs without a clock edge
      kick(2);
      send(32'h1234); send(32'h4321);
      step(); step(); step(); step();
      chk("t5_in_resolve", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", {63'd0, busy}, 64'd0);
      chk("t5_rst_op_ready", {63'd0, op_ready}, 64'd0);
      chk("t5_rst_valid", {63'd0, res_valid}, 64'd0);
      chk("t5_rst_data", {28'd0, res_data}, 64'd0);
      step();
      rst_n = 1'b1;
      step();
      kick(2);
      send(7); send(8);
      wait_done(n);
      chk("t5_latency", 64'(n), 64'd9);
      chk("t5_sum", {28'd0, res_data}, 64'd15);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
